// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register and a one-entry skid buffer.
// Optional FETCH_STALL_CNT_EN adds a saturating 16-bit stall-cycle counter on stall_cnt_o.
module fetch_stage #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               branch_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [ADDR_W-1:0]  if_id_pc_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic               if_id_valid_o,
    output logic               fetch_busy_o
`ifdef FETCH_STALL_CNT_EN
    ,output logic [15:0]       stall_cnt_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   if_id_pc_q, if_id_pc_d;
    logic [INSTR_W-1:0]  if_id_instr_q, if_id_instr_d;
    logic                if_id_valid_q, if_id_valid_d;
    logic [INSTR_W-1:0]  buf_instr_q, buf_instr_d;
    logic                busy_q;
    logic [ADDR_W-1:0]   branch_tgt;
    logic                unused_tgt_bits;

    assign branch_tgt      = {branch_target_i[ADDR_W-1:2], 2'b00};
    assign unused_tgt_bits = ^branch_target_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (branch_i)        state_d = S_FETCH;
                else if (imem_ack_i) state_d = stall_i ? S_HOLD : (start_i ? S_FETCH : S_IDLE);
            end
            S_HOLD: begin
                if (branch_i)        state_d = S_FETCH;
                else if (!stall_i)   state_d = start_i ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PC is untouched while in HOLD, so the skid buffer only needs the instruction word.
    always_comb begin
        imem_req_o    = (state_q == S_FETCH);
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        buf_instr_d   = buf_instr_q;
        unique case (state_q)
            S_IDLE: begin
                if (branch_i) begin
                    pc_d          = branch_tgt;
                    if_id_instr_d = '0;
                    if_id_valid_d = 1'b0;
                end else if (!stall_i) begin
                    if_id_instr_d = '0;
                    if_id_valid_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (branch_i) begin
                    pc_d          = branch_tgt;
                    if_id_instr_d = '0;
                    if_id_valid_d = 1'b0;
                end else if (imem_ack_i && stall_i) begin
                    buf_instr_d   = imem_data_i;
                end else if (imem_ack_i) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = imem_data_i;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_q + ADDR_W'(4);
                end else if (!stall_i) begin
                    if_id_instr_d = '0;
                    if_id_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (branch_i) begin
                    pc_d          = branch_tgt;
                    if_id_instr_d = '0;
                    if_id_valid_d = 1'b0;
                end else if (!stall_i) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = buf_instr_q;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_q + ADDR_W'(4);
                end
            end
            default: begin
                if_id_instr_d = '0;
                if_id_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            if_id_valid_q <= 1'b0;
            buf_instr_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            buf_instr_q   <= buf_instr_d;
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;
    assign fetch_busy_o  = busy_q;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_i && (state_q != S_IDLE) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr ^ KEY so instruction and PC fields differ.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        branch;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_busy;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .stall_i         (stall),
        .branch_i        (branch),
        .branch_target_i (branch_target),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ack_i      (imem_ack),
        .imem_data_i     (imem_data),
        .if_id_pc_o      (if_id_pc),
        .if_id_instr_o   (if_id_instr),
        .if_id_valid_o   (if_id_valid),
        .fetch_busy_o    (fetch_busy)
`ifdef FETCH_STALL_CNT_EN
        ,.stall_cnt_o    (stall_cnt)
`endif
    );

    assign imem_data = imem_addr ^ KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic valid);
        check({tag, ".pc"},    if_id_pc,           pc);
        check({tag, ".instr"}, if_id_instr,        instr);
        check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    endtask

    task automatic check_fe(input string tag, input logic req, input logic [31:0] addr,
                            input logic busy);
        check({tag, ".req"},  {31'b0, imem_req},   {31'b0, req});
        check({tag, ".addr"}, imem_addr,           addr);
        check({tag, ".busy"}, {31'b0, fetch_busy}, {31'b0, busy});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0;
        branch_target = '0; imem_ack = 1'b0;
        tick();
        tick();
        check_fe("rst", 1'b0, 32'h0, 1'b0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_STALL_CNT_EN
        check("rst.stall_cnt", {16'b0, stall_cnt}, 32'd0);
`endif

        // Streaming: ack tied high
        rst = 1'b0; start = 1'b1; imem_ack = 1'b1;
        tick();
        $display("txn start: req=%0d addr=%h", imem_req, imem_addr);
        check_fe("start", 1'b1, 32'h0, 1'b1);
        check_ifid("start", 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("txn stream: if_id pc=%h instr=%h v=%0d", if_id_pc, if_id_instr, if_id_valid);
            check_ifid("stream", 32'(4 * i), 32'(4 * i) ^ KEY, 1'b1);
            check("stream.addr", imem_addr, 32'(4 * i + 4));
        end

        // Delayed ack at 0x10: two bubbles then the instruction
        imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            $display("txn wait: addr=%h v=%0d", imem_addr, if_id_valid);
            check_ifid("wait", 32'hC, 32'h0, 1'b0);
            check_fe("wait", 1'b1, 32'h10, 1'b1);
        end
        imem_ack = 1'b1;
        tick();
        $display("txn ack: if_id pc=%h", if_id_pc);
        check_ifid("late_ack", 32'h10, 32'h10 ^ KEY, 1'b1);
        check("late_ack.addr", imem_addr, 32'h14);
        tick(); tick(); tick();
        check_ifid("pre_stall", 32'h1C, 32'h1C ^ KEY, 1'b1);
        check("pre_stall.addr", imem_addr, 32'h20);

        // Stall coincident with ack at 0x20
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            $display("txn stall: req=%0d if_id pc=%h", imem_req, if_id_pc);
            check_ifid("hold", 32'h1C, 32'h1C ^ KEY, 1'b1);
            check_fe("hold", 1'b0, 32'h20, 1'b1);
        end
        stall = 1'b0;
        tick();
        $display("txn release: if_id pc=%h", if_id_pc);
        check_ifid("release", 32'h20, 32'h20 ^ KEY, 1'b1);
        check_fe("release", 1'b1, 32'h24, 1'b1);
`ifdef FETCH_STALL_CNT_EN
        check("release.stall_cnt", {16'b0, stall_cnt}, 32'd2);
`endif
        tick();
        check_ifid("after_release", 32'h24, 32'h24 ^ KEY, 1'b1);
        check("after_release.addr", imem_addr, 32'h28);

        // Branch while holding: buffer dropped, IF/ID flushed
        stall = 1'b1;
        tick();
        check_fe("hold2", 1'b0, 32'h28, 1'b1);
        branch = 1'b1; branch_target = 32'h103;
        tick();
        $display("txn branch: addr=%h v=%0d", imem_addr, if_id_valid);
        check_ifid("flush", 32'h24, 32'h0, 1'b0);
        check_fe("flush", 1'b1, 32'h100, 1'b1);
        branch = 1'b0; stall = 1'b0;
        tick();
        check_ifid("target", 32'h100, 32'h100 ^ KEY, 1'b1);
        check("target.addr", imem_addr, 32'h104);
`ifdef FETCH_STALL_CNT_EN
        check("branch.stall_cnt", {16'b0, stall_cnt}, 32'd4);
`endif

        // Wrap at top of address space
        branch = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        check_fe("redir_top", 1'b1, 32'hFFFF_FFFC, 1'b1);
        check("redir_top.valid", {31'b0, if_id_valid}, 32'd0);
        branch = 1'b0;
        tick();
        $display("txn wrap: if_id pc=%h addr=%h", if_id_pc, imem_addr);
        check_ifid("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ KEY, 1'b1);
        check("wrap.addr", imem_addr, 32'h0);

        // Asynchronous reset mid-FETCH with ack pending
        imem_ack = 1'b0; start = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("txn async_rst: req=%0d v=%0d pc=%h", imem_req, if_id_valid, if_id_pc);
        check_fe("async_rst", 1'b0, 32'h0, 1'b0);
        check_ifid("async_rst", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_STALL_CNT_EN
        check("async_rst.stall_cnt", {16'b0, stall_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1;
        tick(); tick();
        check_fe("idle_ack", 1'b0, 32'h0, 1'b0);
        check_ifid("idle_ack", 32'h0, 32'h0, 1'b0);

        // Single fetch then return to IDLE when start drops
        start = 1'b1;
        tick();
        check_fe("one_start", 1'b1, 32'h0, 1'b1);
        start = 1'b0;
        tick();
        $display("txn one_shot: if_id pc=%h busy=%0d", if_id_pc, fetch_busy);
        check_ifid("one_shot", 32'h0, 32'h0 ^ KEY, 1'b1);
        check_fe("one_shot", 1'b0, 32'h4, 1'b0);
        tick();
        check_ifid("idle_bubble", 32'h0, 32'h0, 1'b0);
        check("idle_bubble.addr", imem_addr, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
